// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared definitions for the register_divider block: FSM state
//            encoding and the iteration-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CHECK = 2'd1;
  localparam logic [1:0] c_ST_RUN   = 2'd2;
  localparam logic [1:0] c_ST_FIX   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = c_ST_IDLE,
    CHECK = c_ST_CHECK,
    RUN   = c_ST_RUN,
    FIX   = c_ST_FIX
  } state_t;

  // Number of bits needed to count 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration. Shifts the next
//            dividend bit into the partial remainder and subtracts the divisor
//            magnitude when the result stays non-negative.
// Ports    : i_prem  [N:0]  partial remainder before the step
//            i_bit          next dividend bit (MSB first)
//            i_dvs   [N:0]  divisor magnitude
//            o_prem  [N:0]  partial remainder after the step
//            o_qbit         quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0] i_prem,
  input  logic       i_bit,
  input  logic [N:0] i_dvs,
  output logic [N:0] o_prem,
  output logic       o_qbit
);

  logic [N:0]   w_shift;
  logic [N+1:0] w_trial;
  logic         w_unused_msb;

  // The partial remainder is always below the divisor magnitude, so its top
  // bit is zero on entry and the shifted value still fits in N+1 bits.
  assign w_unused_msb = i_prem[N];
  assign w_shift      = {i_prem[N-1:0], i_bit};

  // Extra bit on the trial keeps the borrow; borrow set means restore.
  assign w_trial = {1'b0, w_shift} - {1'b0, i_dvs};
  assign o_qbit  = ~w_trial[N+1];
  assign o_prem  = o_qbit ? w_trial[N:0] : w_shift;

endmodule
`default_nettype wire

// File: rtl/register_divider.sv
`default_nettype none
// ============================================================================
// Module   : register_divider
// Purpose  : Sequential signed divider (2N-bit dividend / N-bit divisor),
//            restoring shift-subtract, one quotient bit per cycle.
// Ports    : clk, reset        clock (rising) / async active-high reset
//            start             request, accepted only while IDLE
//            dividend [2N-1:0] signed dividend
//            divisor  [N-1:0]  signed divisor
//            readEnable        gates quotient/remainder outputs (else 0)
//            quotient [N-1:0]  signed quotient, truncated toward zero
//            remainder[N-1:0]  signed remainder, sign of dividend
//            busy, done        operation in flight / one-cycle completion
//            divByZero         held: last divisor was zero
//            overflow          held: quotient not representable in N bits
//            accessError       one-cycle pulse: start while busy (ignored)
// Revision : 1.0 - initial release
// ============================================================================
module register_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  input  logic           readEnable,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           divByZero,
  output logic           overflow,
  output logic           accessError
);

  localparam int            CW         = clog2(N);
  localparam logic [N-1:0]  C_QMIN_MAG = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_prem;      // partial remainder / upper dividend half
  logic [N-1:0]  r_low;       // lower dividend half, becomes |quotient|
  logic [N:0]    r_dvs;
  logic          r_qsign, r_rsign;
  logic          r_err;       // CHECK found an error; FIX only reports it
  logic [N-1:0]  r_quot, r_rem;
  logic          r_busy, r_done, r_dbz, r_ovf, r_acc;

  // Magnitudes are formed one bit wider so the most-negative operands
  // do not wrap.
  logic [2*N:0] w_dvd_ext, w_dvd_abs;
  logic [N:0]   w_dvs_ext, w_dvs_abs;

  assign w_dvd_ext = {dividend[2*N-1], dividend};
  assign w_dvd_abs = dividend[2*N-1] ? -w_dvd_ext : w_dvd_ext;
  assign w_dvs_ext = {divisor[N-1], divisor};
  assign w_dvs_abs = divisor[N-1] ? -w_dvs_ext : w_dvs_ext;

  logic       w_chk_dbz, w_chk_ovf;
  logic [N:0] w_step_prem;
  logic       w_step_q;

  assign w_chk_dbz = (r_dvs == '0);
  // Upper half already >= divisor means the quotient needs more than N bits.
  assign w_chk_ovf = (r_prem >= r_dvs);

  div_step #(.N(N)) u_step (
    .i_prem (r_prem),
    .i_bit  (r_low[N-1]),
    .i_dvs  (r_dvs),
    .o_prem (w_step_prem),
    .o_qbit (w_step_q)
  );

  logic [N-1:0] w_rmag, w_q_signed, w_r_signed;
  logic         w_fix_ovf;

  assign w_rmag     = r_prem[N-1:0];
  assign w_q_signed = r_qsign ? -r_low : r_low;
  assign w_r_signed = r_rsign ? -w_rmag : w_rmag;
  // A negative quotient may reach -2^(N-1); a positive one may not.
  assign w_fix_ovf  = r_qsign ? (r_low > C_QMIN_MAG) : r_low[N-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CHECK;
      // Error results leave through FIX so done has a fixed 2-edge latency.
      CHECK:   w_next = (w_chk_dbz || w_chk_ovf) ? FIX : RUN;
      RUN:     if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_prem  <= '0;
      r_low   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_err   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_acc   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_acc  <= start && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_prem  <= w_dvd_abs[2*N:N];
            r_low   <= w_dvd_abs[N-1:0];
            r_dvs   <= w_dvs_abs;
            r_qsign <= dividend[2*N-1] ^ divisor[N-1];
            r_rsign <= dividend[2*N-1];
            r_err   <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (w_chk_dbz) begin
            r_dbz <= 1'b1;
            r_err <= 1'b1;
          end else if (w_chk_ovf) begin
            r_ovf <= 1'b1;
            r_err <= 1'b1;
          end else begin
            r_cnt <= C_CNT_LAST;
          end
        end
        RUN: begin
          r_prem <= w_step_prem;
          r_low  <= {r_low[N-2:0], w_step_q};
          r_cnt  <= r_cnt - CW'(1);
        end
        FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_err || w_fix_ovf) begin
            r_quot <= '0;
            r_rem  <= '0;
            if (!r_err) r_ovf <= 1'b1;
          end else begin
            r_quot <= w_q_signed;
            r_rem  <= w_r_signed;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = readEnable ? r_quot : '0;
  assign remainder   = readEnable ? r_rem  : '0;
  assign busy        = r_busy;
  assign done        = r_done;
  assign divByZero   = r_dbz;
  assign overflow    = r_ovf;
  assign accessError = r_acc;

endmodule
`default_nettype wire

// File: doc/register_divider.md
Name: register_divider

Overview:
- Sequential signed divider; the inverse of the registered multiplier datapath.
- Takes a 2N-bit signed dividend, for example a product read back from the multiplier output register, and an N-bit signed divisor.
- Produces an N-bit quotient and an N-bit remainder using a restoring shift-subtract loop, one quotient bit per cycle.
- Sits beside the multiplier on the same register-style bus and reports misuse through an accessError flag.

Parameters:
N, 32, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state and outputs
start  input  1  one-cycle request; operands sampled on the edge where start=1 and the FSM is IDLE
dividend  input  2N  signed dividend
divisor  input  N  signed divisor
readEnable  input  1  when 1, quotient/remainder drive the held results; when 0, they drive 0
quotient  output  N  signed quotient, truncated toward zero
remainder  output  N  signed remainder, sign of dividend
busy  output  1  high from the edge after start through the final FIX cycle
done  output  1  one-cycle pulse when results are valid
divByZero  output  1  held flag, last operation had divisor==0
overflow  output  1  held flag, signed quotient not representable in N bits
accessError  output  1  one-cycle pulse, start asserted while busy (request ignored)

Behaviour:
- Reset values (asynchronous): all outputs 0, internal registers 0, state IDLE.
- A reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE -> CHECK -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 latches the operand magnitudes |dividend| (2N bits) and |divisor| (N bits), plus qSign = sign(dividend) XOR sign(divisor) and rSign = sign(dividend).
  - Clears divByZero and overflow; busy goes to 1.
- CHECK (1 cycle):
  - divisor==0: divByZero=1, quotient=remainder=0, done pulse, go to IDLE.
  - Upper N bits of |dividend| >= |divisor|: overflow=1, results 0, done pulse, go to IDLE.
  - Otherwise go to RUN with the iteration counter at N-1.
- RUN (exactly N cycles), each cycle:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial = partialRem[N:0] - {0,|divisor|} (N+1 bits, keeps the carry).
  - If trial >= 0, keep the trial and shift in quotient bit 1; else restore and shift in 0.
  - Leave RUN when the counter reaches 0.
- FIX (1 cycle):
  - Apply signs: quotient = qSign ? -qMag : qMag; remainder = rSign ? -rMag : rMag.
  - Signed overflow check: qSign=0 and qMag >= 2^(N-1), or qSign=1 and qMag > 2^(N-1). If set, overflow=1 and results are 0.
  - Register the results, pulse done, go to IDLE, busy goes to 0.
- Latency:
  - Normal operation: done is high in the cycle after edge N+2, counting the start edge as edge 0.
  - Error cases: done after edge 2.
- Results and flags hold until the next accepted start.
- start while busy (CHECK/RUN/FIX): request ignored, accessError=1 for one cycle, current operation unaffected.
- start in the same cycle as a done pulse: accepted, because the FSM is IDLE on that edge.
- Most-negative dividend (-2^(2N-1)): the magnitude is computed in 2N+1 bits internally; no wrap.
- Most-negative divisor is handled the same way (N+1-bit magnitude).
- readEnable is combinational output gating only; it never affects the FSM.

Decomposition:
- Package div_pkg:
  - State encoding localparams IDLE/CHECK/RUN/FIX (2 bits).
  - Counter width function clog2(N).
- Sub-module div_step (combinational): one restoring iteration.
  - Inputs: partial remainder (N+1 bits), next dividend bit, |divisor|.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once and reused every RUN cycle.
- The top level holds the FSM, counter, operand/sign registers, sign fix and flags.

Test Plan (N=8):
- 100 / 7 -> after 10 cycles done=1, quotient=14, remainder=2, flags 0.
- -100 / 7 -> quotient=-14, remainder=-2.
- 100 / -7 -> quotient=-14, remainder=2.
- 100 / 0 -> done after 2 cycles, divByZero=1, quotient=remainder=0.
- 4000 / 7 -> CHECK overflow, done after 2 cycles.
- 1024 / 8 -> FIX overflow (qMag=128).
- -1024 / 8 -> quotient=-128, overflow=0.
- 100/7 started, second start at cycle 4 -> accessError pulse, result still 14 r 2.
- 100/7 started, reset pulsed at cycle 5 -> all outputs 0 immediately, no done pulse.
- New start 200/9 -> quotient=22, remainder=2.
- After 100/7 completes, readEnable=0 -> quotient=remainder=0; readEnable=1 -> 14/2 restored.
